imm_encoder: RTL and testbench

Pipelined RV32I instruction encoder: the inverse of the core's immediate decode path. It accepts an immediate value, a format selector using the same `immSrc` encoding as the decode side, and register/opcode fields, then scatters the immediate into a 32-bit instruction word. Illegal immediates are flagged. It sits between the test/boot-program generator and instruction memory, with valid/ready handshakes on both sides and saturating statistics counters.

---
 rtl/imm_encoder.sv | 171 +++++++++++++++++
 tb/tb_imm_encoder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// imm_encoder: two-stage pipelined RV32I instruction encoder.
// Scatters an immediate into a U/I/S/B/J instruction word and flags
// immediates that cannot be represented in the chosen format.
// An illegal word is still delivered, with out_instr=0 and out_err=1.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     input handshake (in_ready is combinational)
//   in_fmt                000 U, 001 I, 010 J, 011 S, 100 B, others illegal
//   in_imm                two's-complement immediate (U: upper-aligned)
//   in_opcode, in_rd, in_rs1, in_rs2, in_funct3   instruction fields
//   out_valid/out_ready   output handshake
//   out_instr, out_err    encoded word and illegal flag
//   enc_count, err_count  saturating delivered / errored-delivered counts
module imm_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [31:0] in_imm,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] enc_count,
  output logic [15:0] err_count
);

  localparam logic [2:0]  FMT_U   = 3'b000;
  localparam logic [2:0]  FMT_I   = 3'b001;
  localparam logic [2:0]  FMT_J   = 3'b010;
  localparam logic [2:0]  FMT_S   = 3'b011;
  localparam logic [2:0]  FMT_B   = 3'b100;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // Stage A: captured input fields
  logic        r_a_valid;
  logic [2:0]  r_a_fmt;
  logic [31:0] r_a_imm;
  logic [6:0]  r_a_opcode;
  logic [4:0]  r_a_rd;
  logic [4:0]  r_a_rs1;
  logic [4:0]  r_a_rs2;
  logic [2:0]  r_a_funct3;

  // Stage B: encoded word
  logic        r_b_valid;
  logic [31:0] r_b_instr;
  logic        r_b_err;
  logic [15:0] r_enc_count;
  logic [15:0] r_err_count;

  logic        w_b_load;
  logic        w_a_load;
  logic        w_deliver;
  logic        w_fits12;
  logic        w_fits13;
  logic        w_fits21;
  logic        w_legal;
  logic [31:0] w_raw;

  assign w_b_load  = ~r_b_valid | out_ready;
  assign in_ready  = ~r_a_valid | w_b_load;
  assign w_a_load  = in_valid & in_ready;
  assign w_deliver = r_b_valid & out_ready;

  // Range checks: the immediate is representable when every bit above the
  // field's sign bit is a copy of it.
  assign w_fits12 = (r_a_imm[31:11] == {21{r_a_imm[11]}});
  assign w_fits13 = (r_a_imm[31:12] == {20{r_a_imm[12]}});
  assign w_fits21 = (r_a_imm[31:20] == {12{r_a_imm[20]}});

  // Field scatter and legality for the word held in stage A
  always_comb begin
    w_raw   = 32'h0000_0000;
    w_legal = 1'b0;
    case (r_a_fmt)
      FMT_U: begin
        w_raw   = {r_a_imm[31:12], r_a_rd, r_a_opcode};
        w_legal = (r_a_imm[11:0] == 12'h000);
      end
      FMT_I: begin
        w_raw   = {r_a_imm[11:0], r_a_rs1, r_a_funct3, r_a_rd, r_a_opcode};
        w_legal = w_fits12;
      end
      FMT_S: begin
        w_raw   = {r_a_imm[11:5], r_a_rs2, r_a_rs1, r_a_funct3,
                   r_a_imm[4:0], r_a_opcode};
        w_legal = w_fits12;
      end
      FMT_B: begin
        w_raw   = {r_a_imm[12], r_a_imm[10:5], r_a_rs2, r_a_rs1, r_a_funct3,
                   r_a_imm[4:1], r_a_imm[11], r_a_opcode};
        w_legal = w_fits13 & ~r_a_imm[0];
      end
      FMT_J: begin
        w_raw   = {r_a_imm[20], r_a_imm[10:1], r_a_imm[11], r_a_imm[19:12],
                   r_a_rd, r_a_opcode};
        w_legal = w_fits21 & ~r_a_imm[0];
      end
      default: begin
        w_raw   = 32'h0000_0000;
        w_legal = 1'b0;
      end
    endcase
  end

  // Stage A register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_valid  <= 1'b0;
      r_a_fmt    <= 3'b000;
      r_a_imm    <= 32'h0000_0000;
      r_a_opcode <= 7'h00;
      r_a_rd     <= 5'h00;
      r_a_rs1    <= 5'h00;
      r_a_rs2    <= 5'h00;
      r_a_funct3 <= 3'b000;
    end else if (in_ready) begin
      r_a_valid <= in_valid;
      if (w_a_load) begin
        r_a_fmt    <= in_fmt;
        r_a_imm    <= in_imm;
        r_a_opcode <= in_opcode;
        r_a_rd     <= in_rd;
        r_a_rs1    <= in_rs1;
        r_a_rs2    <= in_rs2;
        r_a_funct3 <= in_funct3;
      end
    end
  end

  // Stage B register; data only changes when a new word moves in so the
  // output holds steady under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b_valid <= 1'b0;
      r_b_instr <= 32'h0000_0000;
      r_b_err   <= 1'b0;
    end else if (w_b_load) begin
      r_b_valid <= r_a_valid;
      if (r_a_valid) begin
        r_b_instr <= w_legal ? w_raw : 32'h0000_0000;
        r_b_err   <= ~w_legal;
      end
    end
  end

  // Saturating delivery statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_enc_count <= 16'h0000;
      r_err_count <= 16'h0000;
    end else if (w_deliver) begin
      if (r_enc_count != CNT_MAX) r_enc_count <= r_enc_count + 16'd1;
      if (r_b_err && (r_err_count != CNT_MAX)) r_err_count <= r_err_count + 16'd1;
    end
  end

  assign out_valid = r_b_valid;
  assign out_instr = r_b_instr;
  assign out_err   = r_b_err;
  assign enc_count = r_enc_count;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [31:0] in_imm;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] enc_count, err_count;

  imm_encoder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_imm(in_imm), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: {err, instr} from the format rules using integer arithmetic.
  function automatic logic [32:0] model(input logic [2:0] f, input logic [31:0] imm,
                                         input logic [31:0] op, input logic [31:0] rd,
                                         input logic [31:0] rs1, input logic [31:0] rs2,
                                         input logic [31:0] f3);
    int          s;
    logic        ok;
    logic [31:0] w;
    s  = $signed(imm);
    ok = 1'b0;
    w  = 32'h0;
    case (f)
      3'd0: begin
        ok = ((imm & 32'hFFF) == 32'h0);
        w  = (imm & 32'hFFFF_F000) | (rd << 7) | op;
      end
      3'd1: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      end
      3'd3: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
           | ((imm & 32'h1F) << 7) | op;
      end
      3'd4: begin
        ok = (s >= -4096) && (s <= 4094) && ((imm & 32'h1) == 32'h0);
        w  = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
           | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
           | (((imm >> 11) & 32'h1) << 7) | op;
      end
      3'd2: begin
        ok = (s >= -1048576) && (s <= 1048574) && ((imm & 32'h1) == 32'h0);
        w  = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
           | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
           | (rd << 7) | op;
      end
      default: ok = 1'b0;
    endcase
    return {~ok, ok ? w : 32'h0};
  endfunction

  function automatic int sat16(input int m);
    return (m > 65535) ? 65535 : m;
  endfunction

  // Scoreboard state: queue of words inside the DUT, delivered counts
  logic [32:0] expq[$];
  int          enc_m = 0;
  int          err_m = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_instr;
  logic        prev_err;

  // Per-cycle compare, sampled on the falling edge
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst) begin
      expq.delete();
      enc_m      = 0;
      err_m      = 0;
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", 32'(in_ready), 32'((expq.size() < 2) || out_ready));
      chk("enc_count", 32'(enc_count), 32'(sat16(enc_m)));
      chk("err_count", 32'(err_count), 32'(sat16(err_m)));
      if (out_valid && prev_stall) begin
        chk("hold_instr", out_instr, prev_instr);
        chk("hold_err", 32'(out_err), 32'(prev_err));
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("stale_word", 32'(1), 32'(0));
        end else begin
          e = expq.pop_front();
          chk("out_instr", out_instr, e[31:0]);
          chk("out_err", 32'(out_err), 32'(e[32]));
          enc_m++;
          if (e[32]) err_m++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_instr = out_instr;
      prev_err   = out_err;
      if (in_valid && in_ready)
        expq.push_back(model(in_fmt, in_imm, 32'(in_opcode), 32'(in_rd),
                             32'(in_rs1), 32'(in_rs2), 32'(in_funct3)));
    end
  end

  task automatic send(input logic [2:0] f, input logic [31:0] imm, input logic [6:0] op,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [2:0] f3);
    in_fmt = f; in_imm = imm; in_opcode = op;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_funct3 = f3;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) break;
      if (i == 49) chk("send_timeout", 32'(0), 32'(1));
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    if (!out_valid) chk("valid_timeout", 32'(0), 32'(1));
  endtask

  task automatic expect_out(input string name, input logic [31:0] instr, input logic err);
    wait_valid();
    chk(name, out_instr, instr);
    chk({name, "_err"}, 32'(out_err), 32'(err));
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  logic [31:0] hold_i;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_fmt = 3'd0; in_imm = 32'h0; in_opcode = 7'h0;
    in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_funct3 = 3'd0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_enc_count", 32'(enc_count), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // I format with latency check
    send(3'd1, 32'd5, 7'h13, 5'd1, 5'd0, 5'd7, 3'd0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_early_valid", 32'(out_valid), 32'(0));
    @(negedge clk);
    chk("lat_valid", 32'(out_valid), 32'(1));
    chk("i_addi", out_instr, 32'h0050_0093);

    send(3'd0, 32'h1234_5000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0);
    in_valid = 1'b0;
    expect_out("u_lui", 32'h1234_52B7, 1'b0);
    send(3'd0, 32'h1234_5001, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0);
    in_valid = 1'b0;
    expect_out("u_bad", 32'h0, 1'b1);
    @(negedge clk);
    chk("u_bad_err_count", 32'(err_count), 32'(1));

    send(3'd4, 32'hFFFF_FFFC, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0);
    in_valid = 1'b0;
    expect_out("b_neg4", 32'hFE00_0EE3, 1'b0);
    send(3'd4, 32'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0);
    in_valid = 1'b0;
    expect_out("b_odd", 32'h0, 1'b1);
    send(3'd3, 32'd8, 7'h23, 5'd0, 5'd3, 5'd2, 3'd2);
    in_valid = 1'b0;
    expect_out("s_sw", 32'h0021_A423, 1'b0);
    send(3'd2, 32'd2048, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0);
    in_valid = 1'b0;
    expect_out("j_jal", 32'h0010_00EF, 1'b0);
    send(3'd1, 32'd2048, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0);
    in_valid = 1'b0;
    expect_out("i_2048", 32'h0, 1'b1);
    send(3'd2, 32'd1048574, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0);
    in_valid = 1'b0;
    wait_valid();
    chk("j_max_err", 32'(out_err), 32'(0));

    // Back-to-back stream with a three-cycle stall
    do_reset();
    fork
      begin
        send(3'd1, 32'd1,          7'h13, 5'd1, 5'd2, 5'd0, 3'd0);
        send(3'd1, 32'hFFFF_F800,  7'h13, 5'd2, 5'd3, 5'd0, 3'd4);
        send(3'd6, 32'd0,          7'h13, 5'd3, 5'd4, 5'd0, 3'd0);
        send(3'd3, 32'hFFFF_FFFF,  7'h23, 5'd0, 5'd5, 5'd6, 3'd2);
        in_valid = 1'b0;
      end
      begin
        wait_valid();
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 32'(0));
        hold_i = out_instr;
        repeat (2) @(negedge clk);
        chk("bp_hold", out_instr, hold_i);
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    repeat (6) @(negedge clk);
    chk("stream_enc_count", 32'(enc_count), 32'(4));
    chk("stream_err_count", 32'(err_count), 32'(1));

    // Saturation run, then reset with a word in flight
    do_reset();
    in_fmt = 3'd1; in_imm = 32'd100; in_opcode = 7'h13;
    in_rd = 5'd1; in_rs1 = 5'd1; in_rs2 = 5'd0; in_funct3 = 3'd0;
    in_valid = 1'b1;
    repeat (65545) @(posedge clk);
    @(negedge clk);
    chk("sat_enc_count", 32'(enc_count), 32'h0000_FFFF);
    chk("sat_err_count", 32'(err_count), 32'(0));
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'(0));
    chk("midrst_enc_count", 32'(enc_count), 32'(0));
    chk("midrst_err_count", 32'(err_count), 32'(0));
    chk("midrst_in_ready", 32'(in_ready), 32'(1));
    in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
